// File: rtl/welch_preprocessor.sv
// welch_preprocessor
//   Front end of the Welch PSD pipeline on the 10G RX path. It strips a
//   programmable number of header beats from each incoming AXI-Stream frame
//   and queues the remaining payload beats in a FIFO. Forwarding is gated by
//   the CPU-controlled enable and arm bits. The FIFO is needed because the
//   input stream cannot be stalled, while the output stream can.
//
//   Optional build macro: WELCH_PP_BYTESWAP_EN. When it is defined, the two
//   bytes of every 16-bit sample on m_axis_tdata are swapped, and each pair
//   of bits in m_axis_tkeep is swapped to match.
//
// Ports
//   clk, resetn          single clock, asynchronous active-low reset
//   s_axis_*             raw MAC stream in (no tready, always accepted)
//   cpu_aw*/w*/b*        AXI-Lite write channel (full-word writes)
//   cpu_ar*/r*           AXI-Lite read channel
//   m_axis_*             payload stream out; tuser marks the first payload beat
//
// Register map (byte address, decoded on addr[3:2]; only 0x0-0xF is mapped)
//   0x0 CTRL      bit0 enable (reset 1), bit1 arm (reset 0)
//   0x4 HDR_SKIP  [15:0] header beats to drop
//   0x8 FRAME_CNT RO, frames fully forwarded
//   0xC STATUS    bit0 overflow, sticky, write 1 to clear
//
// Parser states
//   state     | meaning
//   S_IDLE    | at a frame boundary; this beat opens a new frame
//   S_HDR     | dropping header beats; hdr_left beats are still to drop
//   S_PAYLOAD | forwarding payload beats into the FIFO
//   S_DROP    | discarding beats up to and including tlast

module welch_preprocessor #(
  parameter int          FIFO_DEPTH   = 512,
  parameter logic [15:0] HDR_SKIP_RST = 16'd4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  input  logic [31:0] cpu_awaddr,
  input  logic        cpu_awvalid,
  output logic        cpu_awready,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_wvalid,
  output logic        cpu_wready,
  output logic [1:0]  cpu_bresp,
  output logic        cpu_bvalid,
  input  logic        cpu_bready,
  input  logic [31:0] cpu_araddr,
  input  logic        cpu_arvalid,
  output logic        cpu_arready,
  output logic [31:0] cpu_rdata,
  output logic [1:0]  cpu_rresp,
  output logic        cpu_rvalid,
  input  logic        cpu_rready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 74;  // {user, last, keep[7:0], data[63:0]}

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP} state_t;

  state_t        state;
  logic [15:0]   hdr_left;
  logic          frame_open;
  logic          tlast_pend;
  logic [63:0]   hold_data;
  logic [7:0]    hold_keep;

  logic          ctrl_enable;
  logic          ctrl_arm;
  logic [15:0]   hdr_skip;
  logic [31:0]   frame_cnt;
  logic          sts_overflow;

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [63:0]   out_data;
  logic [7:0]    out_keep;

  logic          full;
  logic          can_accept;
  logic          is_payload;
  logic          is_first;
  logic          pl_wr;
  logic          ovf;
  logic          close_beat;
  logic          close_direct;
  logic          close_pend_set;
  logic          pend_wr;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [FW-1:0] wr_word;

  logic          wr_mapped;
  logic [31:0]   rd_word;
  logic          unused_bits;

  assign unused_bits = ^{s_axis_tuser, cpu_awaddr[1:0], cpu_araddr[1:0], cpu_wdata[31:16]};

  // ---------------- beat classification ----------------
  always_comb begin
    is_payload = 1'b0;
    is_first   = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        S_IDLE: begin
          if (ctrl_enable && ctrl_arm && hdr_skip == 16'd0) begin
            is_payload = 1'b1;
            is_first   = 1'b1;
          end
        end
        S_HDR: begin
          if (hdr_left == 16'd0) begin
            is_payload = 1'b1;
            is_first   = 1'b1;
          end
        end
        S_PAYLOAD: is_payload = 1'b1;
        default: ;
      endcase
    end
  end

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  // A pending closing beat must enter the FIFO before anything from the next frame.
  assign can_accept = !full && !tlast_pend;
  assign pl_wr      = is_payload && can_accept;
  assign ovf        = is_payload && !can_accept;

  // The frame's tlast arrives after part of the frame is already queued but its
  // tail was lost to overflow. Downstream still needs a tlast to close the frame.
  assign close_beat     = s_axis_tvalid && s_axis_tlast && frame_open && (state == S_DROP || ovf);
  assign close_direct   = close_beat && can_accept;
  assign close_pend_set = close_beat && !can_accept;
  assign pend_wr        = tlast_pend && !full;

  assign fifo_wr = pl_wr || close_direct || pend_wr;
  assign fifo_rd = (count != '0) && (!m_axis_tvalid || m_axis_tready);
  assign wr_word = pend_wr ? {1'b0, 1'b1, hold_keep, hold_data}
                           : {is_first, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  // ---------------- parser FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      hdr_left   <= 16'd0;
      frame_open <= 1'b0;
      tlast_pend <= 1'b0;
      hold_data  <= 64'd0;
      hold_keep  <= 8'd0;
    end else begin
      if (pend_wr)
        tlast_pend <= 1'b0;
      if (close_pend_set) begin
        tlast_pend <= 1'b1;
        hold_data  <= s_axis_tdata;
        hold_keep  <= s_axis_tkeep;
      end

      if (pl_wr)
        frame_open <= !s_axis_tlast;
      else if (close_direct || close_pend_set)
        frame_open <= 1'b0;

      if (s_axis_tvalid) begin
        if (s_axis_tlast) begin
          state <= S_IDLE;
        end else begin
          case (state)
            S_IDLE: begin
              if (ctrl_enable && ctrl_arm) begin
                if (hdr_skip == 16'd0) begin
                  state <= can_accept ? S_PAYLOAD : S_DROP;
                end else begin
                  state    <= S_HDR;
                  hdr_left <= hdr_skip - 16'd1;
                end
              end else begin
                state <= S_DROP;
              end
            end
            S_HDR: begin
              if (hdr_left == 16'd0)
                state <= can_accept ? S_PAYLOAD : S_DROP;
              else
                hdr_left <= hdr_left - 16'd1;
            end
            S_PAYLOAD: begin
              if (!can_accept)
                state <= S_DROP;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- payload FIFO + output register ----------------
  always_ff @(posedge clk) begin
    if (fifo_wr)
      mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      out_data      <= 64'd0;
      out_keep      <= 8'd0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (fifo_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        {m_axis_tuser, m_axis_tlast, out_keep, out_data} <= mem[rd_ptr];
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      count <= count + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);
    end
  end

`ifdef WELCH_PP_BYTESWAP_EN
  for (genvar i = 0; i < 4; i++) begin : g_swap
    assign m_axis_tdata[16*i +: 16] = {out_data[16*i +: 8], out_data[16*i+8 +: 8]};
    assign m_axis_tkeep[2*i +: 2]   = {out_keep[2*i], out_keep[2*i+1]};
  end
`else
  assign m_axis_tdata = out_data;
  assign m_axis_tkeep = out_keep;
`endif

  // ---------------- registers ----------------
  assign wr_mapped = (cpu_awaddr[31:4] == 28'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_enable  <= 1'b1;
      ctrl_arm     <= 1'b0;
      hdr_skip     <= HDR_SKIP_RST;
      frame_cnt    <= 32'd0;
      sts_overflow <= 1'b0;
    end else begin
      // awready is a one-cycle pulse, so it marks exactly one write per transaction.
      if (cpu_awready && wr_mapped) begin
        case (cpu_awaddr[3:2])
          2'd0: begin
            ctrl_enable <= cpu_wdata[0];
            ctrl_arm    <= cpu_wdata[1];
          end
          2'd1: hdr_skip <= cpu_wdata[15:0];
          2'd3: if (cpu_wdata[0]) sts_overflow <= 1'b0;
          default: ;
        endcase
      end
      if (ovf)
        sts_overflow <= 1'b1;
      if (pl_wr && s_axis_tlast)
        frame_cnt <= frame_cnt + 32'd1;
    end
  end

  always_comb begin
    rd_word = 32'd0;
    if (cpu_araddr[31:4] == 28'd0) begin
      case (cpu_araddr[3:2])
        2'd0: rd_word = {30'd0, ctrl_arm, ctrl_enable};
        2'd1: rd_word = {16'd0, hdr_skip};
        2'd2: rd_word = frame_cnt;
        2'd3: rd_word = {31'd0, sts_overflow};
        default: ;
      endcase
    end
  end

  // ---------------- AXI-Lite handshakes ----------------
  assign cpu_wready = cpu_awready;
  assign cpu_bresp  = 2'b00;
  assign cpu_rresp  = 2'b00;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpu_awready <= 1'b0;
      cpu_bvalid  <= 1'b0;
      cpu_arready <= 1'b0;
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= 32'd0;
    end else begin
      cpu_awready <= cpu_awvalid && cpu_wvalid && !cpu_awready && !cpu_bvalid;
      if (cpu_awready)
        cpu_bvalid <= 1'b1;
      else if (cpu_bready)
        cpu_bvalid <= 1'b0;

      cpu_arready <= cpu_arvalid && !cpu_arready && !cpu_rvalid;
      if (cpu_arready) begin
        cpu_rvalid <= 1'b1;
        cpu_rdata  <= rd_word;
      end else if (cpu_rready) begin
        cpu_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_welch_preprocessor.sv
// tb_welch_preprocessor
//   Drives frames into welch_preprocessor and drives the CPU bus. Expected
//   output comes from a frame-level model: in an armed frame, beat i is
//   forwarded when i >= HDR_SKIP. The bench also checks register behaviour,
//   the output latency and the overflow/close path.
`timescale 1ns/1ps

module tb_welch_preprocessor;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic [31:0] cpu_awaddr = '0;
  logic        cpu_awvalid = 1'b0;
  logic        cpu_awready;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_wvalid = 1'b0;
  logic        cpu_wready;
  logic [1:0]  cpu_bresp;
  logic        cpu_bvalid;
  logic        cpu_bready = 1'b0;
  logic [31:0] cpu_araddr = '0;
  logic        cpu_arvalid = 1'b0;
  logic        cpu_arready;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_rresp;
  logic        cpu_rvalid;
  logic        cpu_rready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;

  always #5 clk = ~clk;

  welch_preprocessor dut (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
    .cpu_awaddr(cpu_awaddr), .cpu_awvalid(cpu_awvalid), .cpu_awready(cpu_awready),
    .cpu_wdata(cpu_wdata), .cpu_wvalid(cpu_wvalid), .cpu_wready(cpu_wready),
    .cpu_bresp(cpu_bresp), .cpu_bvalid(cpu_bvalid), .cpu_bready(cpu_bready),
    .cpu_araddr(cpu_araddr), .cpu_arvalid(cpu_arvalid), .cpu_arready(cpu_arready),
    .cpu_rdata(cpu_rdata), .cpu_rresp(cpu_rresp), .cpu_rvalid(cpu_rvalid), .cpu_rready(cpu_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t exp_q[$];
  beat_t cap_q[$];
  beat_t frm[$];

  int n_vec = 0;
  int n_err = 0;
  int got_cnt = 0;
  int exp_cnt = 0;
  int mon_mode = 0;   // 0: compare against model, 1: capture raw
  int rdy_mode = 1;   // 0: random, 1: always ready, 2: never ready
  logic m_en = 1'b1;
  logic m_arm = 1'b0;
  int m_skip = 4;
  int m_fcnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output byte j comes from input byte j^1 when samples are byte-swapped.
  function automatic logic [63:0] exp_d(input logic [63:0] d);
    logic [63:0] r;
    r = d;
`ifdef WELCH_PP_BYTESWAP_EN
    for (int j = 0; j < 8; j++) r[8*j +: 8] = d[8*(j^1) +: 8];
`endif
    return r;
  endfunction

  function automatic logic [7:0] exp_k(input logic [7:0] k);
    logic [7:0] r;
    r = k;
`ifdef WELCH_PP_BYTESWAP_EN
    for (int j = 0; j < 8; j++) r[j] = k[j^1];
`endif
    return r;
  endfunction

  task automatic model_frame();
    beat_t b;
    if (m_en && m_arm && frm.size() > m_skip) begin
      for (int i = m_skip; i < frm.size(); i++) begin
        b.d = exp_d(frm[i].d);
        b.k = exp_k(frm[i].k);
        b.l = (i == frm.size() - 1);
        b.u = (i == m_skip);
        exp_q.push_back(b);
        exp_cnt++;
      end
      m_fcnt++;
    end
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < frm.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frm[i].d;
      s_axis_tkeep  = frm[i].k;
      s_axis_tlast  = (i == frm.size() - 1);
      s_axis_tuser  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (10) begin @(posedge clk); #1; end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("beat_count", 64'(got_cnt), 64'(exp_cnt));
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    int t;
    t = 0;
    cpu_awaddr = a; cpu_wdata = d; cpu_awvalid = 1'b1; cpu_wvalid = 1'b1;
    do begin @(posedge clk); #1; t++; end while (!cpu_awready && t < 50);
    chk("awready", 64'(cpu_awready & cpu_wready), 64'd1);
    @(posedge clk); #1;
    cpu_awvalid = 1'b0; cpu_wvalid = 1'b0;
    t = 0;
    while (!cpu_bvalid && t < 50) begin @(posedge clk); #1; t++; end
    chk("bvalid", 64'(cpu_bvalid), 64'd1);
    chk("bresp", 64'(cpu_bresp), 64'd0);
    cpu_bready = 1'b1;
    @(posedge clk); #1;
    cpu_bready = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    int t;
    t = 0;
    cpu_araddr = a; cpu_arvalid = 1'b1;
    do begin @(posedge clk); #1; t++; end while (!cpu_arready && t < 50);
    chk("arready", 64'(cpu_arready), 64'd1);
    @(posedge clk); #1;
    cpu_arvalid = 1'b0;
    t = 0;
    while (!cpu_rvalid && t < 50) begin @(posedge clk); #1; t++; end
    chk("rvalid", 64'(cpu_rvalid), 64'd1);
    chk("rresp", 64'(cpu_rresp), 64'd0);
    d = cpu_rdata;
    cpu_rready = 1'b1;
    @(posedge clk); #1;
    cpu_rready = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] v;
    cpu_read(a, v);
    chk(tag, 64'(v), 64'(e));
  endtask

  task automatic load_t1_frame();
    logic [63:0] dd [9];
    beat_t b;
    dd = '{64'hFFFFFFFFFFFF1122, 64'h5566778800081122, 64'h33445566778899AA,
           64'hBBCCDDEEFF112233, 64'hCAFECAFECAFECAFE, 64'hCAFECAFECAFECAFE,
           64'hCAFECAFECAFECAFE, 64'hCAFECAFECAFECAFE, 64'hDEADDEADDEADDEAD};
    frm.delete();
    for (int i = 0; i < 9; i++) begin
      b.d = dd[i]; b.k = 8'hFF; b.l = 1'b0; b.u = 1'b0;
      frm.push_back(b);
    end
  endtask

  // Output ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_axis_tready = 1'($urandom_range(0, 1));
        1: m_axis_tready = 1'b1;
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor; a transfer seen here completes on the next rising edge.
  always @(negedge clk) begin
    beat_t b;
    beat_t e;
    if (resetn && m_axis_tvalid && m_axis_tready) begin
      b.d = m_axis_tdata; b.k = m_axis_tkeep; b.l = m_axis_tlast; b.u = m_axis_tuser;
      if (mon_mode == 1) begin
        cap_q.push_back(b);
      end else begin
        got_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", b.d, e.d);
          chk("out_keep", 64'(b.k), 64'(e.k));
          chk("out_last", 64'(b.l), 64'(e.l));
          chk("out_user", 64'(b.u), 64'(e.u));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    beat_t b;
    int n, bad, lasts, t, len;
    logic [31:0] v;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_tlast_tuser", 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
    chk("rst_cpu_ready", 64'({cpu_awready, cpu_wready, cpu_arready}), 64'd0);
    chk("rst_cpu_valid", 64'({cpu_bvalid, cpu_rvalid}), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    reg_chk("ctrl_rst", 32'h0, 32'h1);
    reg_chk("skip_rst", 32'h4, 32'd4);
    reg_chk("fcnt_rst", 32'h8, 32'd0);
    reg_chk("status_rst", 32'hC, 32'd0);

    // Armed 9-beat frame, 4 header beats
    cpu_write(32'h0, 32'h3); m_arm = 1'b1;
    load_t1_frame(); model_frame(); send_frame(1'b0); wait_drain();
    reg_chk("fcnt_armed", 32'h8, 32'(m_fcnt));

    // Disarmed: nothing forwarded
    cpu_write(32'h0, 32'h1); m_arm = 1'b0;
    load_t1_frame(); model_frame(); send_frame(1'b0); wait_drain();
    reg_chk("fcnt_disarmed", 32'h8, 32'(m_fcnt));

    // HDR_SKIP = 0 and HDR_SKIP beyond frame length
    cpu_write(32'h0, 32'h3); m_arm = 1'b1;
    cpu_write(32'h4, 32'd0); m_skip = 0;
    load_t1_frame(); model_frame(); send_frame(1'b1); wait_drain();
    cpu_write(32'h4, 32'd12); m_skip = 12;
    load_t1_frame(); model_frame(); send_frame(1'b0); wait_drain();
    reg_chk("fcnt_skip", 32'h8, 32'(m_fcnt));

    // Arm cleared mid-frame: current frame completes, next is dropped
    cpu_write(32'h4, 32'd4); m_skip = 4;
    load_t1_frame(); model_frame();
    fork
      send_frame(1'b0);
      begin repeat (2) begin @(posedge clk); #1; end cpu_write(32'h0, 32'h1); end
    join
    m_arm = 1'b0;
    load_t1_frame(); model_frame(); send_frame(1'b0);
    // Arm set mid-frame: takes effect at the next boundary
    load_t1_frame(); model_frame();
    fork
      send_frame(1'b0);
      begin repeat (2) begin @(posedge clk); #1; end cpu_write(32'h0, 32'h3); end
    join
    m_arm = 1'b1;
    load_t1_frame(); model_frame(); send_frame(1'b0); wait_drain();
    reg_chk("fcnt_midframe", 32'h8, 32'(m_fcnt));

    // Latency and byte order on an empty pipeline
    cpu_write(32'h4, 32'd0); m_skip = 0;
    frm.delete();
    b.d = 64'h1122334455667788; b.k = 8'hFF; b.l = 1'b0; b.u = 1'b0;
    frm.push_back(b);
    model_frame();
    s_axis_tdata = 64'h1122334455667788; s_axis_tkeep = 8'hFF;
    s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("lat_1clk", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk); #1;
    chk("lat_2clk", 64'(m_axis_tvalid), 64'd1);
`ifdef WELCH_PP_BYTESWAP_EN
    chk("byteswap", m_axis_tdata, 64'h2211443366558877);
`else
    chk("passthru", m_axis_tdata, 64'h1122334455667788);
`endif
    wait_drain();

    // Register access
    cpu_write(32'h4, 32'd2); m_skip = 2;
    reg_chk("skip_rb", 32'h4, 32'd2);
    reg_chk("unmapped_rd", 32'h10, 32'd0);
    cpu_write(32'h14, 32'd7);
    reg_chk("unmapped_wr", 32'h4, 32'd2);

    // Overflow: output stalled through a 600-beat payload
    cpu_write(32'h4, 32'd4); m_skip = 4;
    rdy_mode = 2; mon_mode = 1;
    @(posedge clk); #1;
    frm.delete();
    for (int i = 0; i < 604; i++) begin
      b.d = {32'hA5A50000, 32'(i)}; b.k = 8'hFF; b.l = 1'b0; b.u = 1'b0;
      frm.push_back(b);
    end
    send_frame(1'b0);
    reg_chk("ovf_status", 32'hC, 32'd1);
    rdy_mode = 1;
    t = 0;
    while (t < 1500) begin @(posedge clk); #1; t++; end
    mon_mode = 0;
    n = cap_q.size();
    chk("ovf_len_ok", 64'(n >= DEPTH + 1 && n <= DEPTH + 2), 64'd1);
    bad = 0; lasts = 0;
    for (int i = 0; i < n; i++) begin
      if (cap_q[i].l) lasts++;
      if (i < n - 1 && cap_q[i].d !== exp_d(frm[4 + i].d)) bad++;
    end
    chk("ovf_data_bad", 64'(bad), 64'd0);
    chk("ovf_tlast_count", 64'(lasts), 64'd1);
    if (n > 0) begin
      chk("ovf_first_user", 64'(cap_q[0].u), 64'd1);
      chk("ovf_close_last", 64'(cap_q[n-1].l), 64'd1);
      chk("ovf_close_data", cap_q[n-1].d, exp_d(frm[603].d));
    end
    reg_chk("fcnt_ovf", 32'h8, 32'(m_fcnt));
    cpu_write(32'hC, 32'h1);
    reg_chk("status_w1c", 32'hC, 32'd0);

    // Randomized frames, configuration changed only between frames
    rdy_mode = 0;
    for (int f = 0; f < 24; f++) begin
      m_skip = $urandom_range(0, 5);
      m_en   = ($urandom_range(0, 7) != 0);
      m_arm  = ($urandom_range(0, 3) != 0);
      cpu_write(32'h4, 32'(m_skip));
      cpu_write(32'h0, {30'd0, m_arm, m_en});
      len = $urandom_range(1, 12);
      frm.delete();
      for (int i = 0; i < len; i++) begin
        b.d = {$urandom, $urandom};
        b.k = (i == len - 1) ? 8'($urandom) : 8'hFF;
        b.l = 1'b0; b.u = 1'b0;
        frm.push_back(b);
      end
      model_frame();
      send_frame(1'b1);
    end
    wait_drain();
    reg_chk("fcnt_random", 32'h8, 32'(m_fcnt));
    reg_chk("status_random", 32'hC, 32'd0);
    cpu_read(32'h0, v);
    chk("ctrl_random", 64'(v), 64'({m_arm, m_en}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
